// File: rtl/ifu_prefetch_queue_if.sv
// Fetch-unit bus bundle: memory request/response port, IDU output port and redirect.
// master = fetch unit side, slave = memory/IDU/control side.
interface ifu_prefetch_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;
  logic            out_err;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output req_valid, req_addr, out_valid, out_pc, out_inst, out_err,
    input  req_ready, rsp_valid, rsp_data, rsp_err, out_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr, out_valid, out_pc, out_inst, out_err,
    output req_ready, rsp_valid, rsp_data, rsp_err, out_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_prefetch_queue.sv
// Instruction prefetch queue: credit-limited sequential fetch, in-order {pc,inst,err}
// queue to the IDU, redirect with stale-response discard, halt after access fault.
module ifu_prefetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     MAX_OS   = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input logic                  clk,
  input logic                  rst,
  ifu_prefetch_queue_if.master bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OS + 1);
  localparam int unsigned PW = (MAX_OS > 1) ? $clog2(MAX_OS) : 1;
  localparam int unsigned SW = $clog2(DEPTH + MAX_OS + 1);

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d;
  logic            stale_q, stale_d;
  logic [OW-1:0]   os_q, os_d;
  logic [OW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   pcf_rd_q, pcf_rd_d;
  logic [PW-1:0]   pcf_wr_q, pcf_wr_d;

  logic [XLEN-1:0] q_pc_q   [DEPTH];
  logic [XLEN-1:0] q_inst_q [DEPTH];
  logic            q_err_q  [DEPTH];
  logic [XLEN-1:0] pcf_q    [MAX_OS];

  logic [SW-1:0]   occ;
  logic            credit;
  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            fire;
  logic            redirect;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic            out_valid;
  logic [XLEN-1:0] rsp_pc;

  function automatic logic [PW-1:0] pcf_next(input logic [PW-1:0] p);
    return (p == PW'(MAX_OS - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    occ       = SW'(count_q) + SW'(os_q);
    credit    = (state_q == ST_RUN) && (os_q < OW'(MAX_OS)) && (occ < SW'(DEPTH));
    // A launched request is held by pend_q; rst gating keeps req_valid low in reset.
    req_valid = rst && (pend_q || credit);
    req_addr  = pend_q ? pend_addr_q : fetch_pc_q;
    fire      = req_valid && bus.req_ready;
    redirect  = bus.redirect_valid;
    rsp_drop  = bus.rsp_valid && (drop_q != '0);
    push      = bus.rsp_valid && (drop_q == '0) && !redirect;
    out_valid = (count_q != '0);
    pop       = out_valid && bus.out_ready && !redirect;
    rsp_pc    = pcf_q[pcf_rd_q];
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pend_d      = req_valid && !bus.req_ready;
    pend_addr_d = req_addr;
    stale_d     = stale_q && !fire;
    os_d        = os_q;
    drop_d      = drop_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    pcf_rd_d    = pcf_rd_q;
    pcf_wr_d    = pcf_wr_q;

    if (fire) begin
      os_d     = os_d + OW'(1);
      pcf_wr_d = pcf_next(pcf_wr_q);
      if (!stale_q) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (stale_q)  drop_d     = drop_d + OW'(1);
    end
    if (bus.rsp_valid) begin
      os_d     = os_d - OW'(1);
      pcf_rd_d = pcf_next(pcf_rd_q);
    end
    if (rsp_drop) drop_d = drop_d - OW'(1);

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (bus.rsp_err) state_d = ST_HALT;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    // Every request outstanding after this edge belongs to the old stream; a
    // launched-but-unfired request is marked stale and counted when it fires.
    if (redirect) begin
      state_d    = ST_RUN;
      fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
      drop_d     = os_d;
      stale_d    = req_valid && !bus.req_ready;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      fetch_pc_q  <= RESET_PC;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      stale_q     <= 1'b0;
      os_q        <= '0;
      drop_q      <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      pcf_rd_q    <= '0;
      pcf_wr_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      stale_q     <= stale_d;
      os_q        <= os_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      pcf_rd_q    <= pcf_rd_d;
      pcf_wr_q    <= pcf_wr_d;
    end
  end

  // Payload storage needs no reset: contents are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc_q[wr_ptr_q]   <= rsp_pc;
      q_inst_q[wr_ptr_q] <= bus.rsp_data;
      q_err_q[wr_ptr_q]  <= bus.rsp_err;
    end
    if (fire) pcf_q[pcf_wr_q] <= req_addr;
  end

  assign bus.req_valid = req_valid;
  assign bus.req_addr  = req_addr;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = out_valid ? q_pc_q[rd_ptr_q]   : '0;
  assign bus.out_inst  = out_valid ? q_inst_q[rd_ptr_q] : '0;
  assign bus.out_err   = out_valid ? q_err_q[rd_ptr_q]  : 1'b0;

  a_rsp_owed: assert property (@(posedge clk) disable iff (!rst)
    bus.rsp_valid |-> (os_q != '0));

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Randomized bench for ifu_prefetch_queue: in-order memory responder plus a
// stream-level reference model of expected requests and delivered entries.
module tb_ifu_prefetch_queue;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_OS   = 2;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ifu_prefetch_queue_if #(.XLEN(XLEN)) bus ();

  ifu_prefetch_queue #(
    .XLEN    (XLEN),
    .DEPTH   (DEPTH),
    .MAX_OS  (MAX_OS),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { logic [31:0] addr; int due; }                     mreq_t;
  typedef struct { logic [31:0] addr; bit live; }                    ost_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; bit err; }    ent_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mreq_t respq[$];
  ost_t  outst[$];
  ent_t  expq[$];
  logic [31:0] exp_next, pend_addr;
  bit          pend_m, stale_m, halted;

  int          ready_pct = 100, oready_pct = 100, lat_min = 1, lat_max = 1;
  logic [31:0] err_addr = '0;
  bit          rand_err = 1'b0;

  int          dut_pops = 0, dut_fires = 0;
  bit          want_first = 1'b0, err_seen = 1'b0;
  logic [31:0] first_pop_pc = '0, err_pc = '0;

  function automatic logic [31:0] mem_inst(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic bit mem_err(input logic [31:0] a);
    return (a == err_addr) || (rand_err && (((a >> 2) % 19) == 7));
  endfunction

  task automatic drive_idle();
    bus.req_ready      = 1'b0;
    bus.rsp_valid      = 1'b0;
    bus.rsp_data       = '0;
    bus.rsp_err        = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
  endtask

  task automatic model_reset();
    respq.delete();
    outst.delete();
    expq.delete();
    exp_next = RESET_PC;
    pend_addr = '0;
    pend_m = 1'b0;
    stale_m = 1'b0;
    halted = 1'b0;
  endtask

  // One clock: drive inputs at negedge, compare against the model, advance model.
  task automatic step(input bit redir = 1'b0, input logic [31:0] rpc = '0);
    bit exp_rv, exp_ov, fire_m;
    logic [31:0] exp_addr;
    ost_t o;
    ent_t e;
    @(negedge clk);
    cyc++;
    if (respq.size() > 0 && respq[0].due <= cyc) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = mem_inst(respq[0].addr);
      bus.rsp_err   = mem_err(respq[0].addr);
      void'(respq.pop_front());
    end else begin
      bus.rsp_valid = 1'b0;
      bus.rsp_data  = $urandom;
      bus.rsp_err   = 1'b0;
    end
    bus.req_ready      = ($urandom_range(99) < ready_pct);
    bus.out_ready      = ($urandom_range(99) < oready_pct);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    #1;

    exp_rv   = pend_m || (!halted && outst.size() < MAX_OS && (expq.size() + outst.size()) < DEPTH);
    exp_addr = pend_m ? pend_addr : exp_next;
    total++;
    if (bus.req_valid !== exp_rv) begin
      bad++;
      $display("FAIL req_valid cyc=%0d got=%0b exp=%0b", cyc, bus.req_valid, exp_rv);
    end
    if (exp_rv) begin
      total++;
      if (bus.req_addr !== exp_addr) begin
        bad++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, bus.req_addr, exp_addr);
      end
    end
    exp_ov = (expq.size() != 0);
    total++;
    if (bus.out_valid !== exp_ov) begin
      bad++;
      $display("FAIL out_valid cyc=%0d got=%0b exp=%0b", cyc, bus.out_valid, exp_ov);
    end
    total++;
    if (exp_ov) begin
      if ({bus.out_pc, bus.out_inst, bus.out_err} !== {expq[0].pc, expq[0].inst, expq[0].err}) begin
        bad++;
        $display("FAIL out_head cyc=%0d got pc=%h inst=%h err=%0b exp pc=%h inst=%h err=%0b",
                 cyc, bus.out_pc, bus.out_inst, bus.out_err, expq[0].pc, expq[0].inst, expq[0].err);
      end
    end else if ({bus.out_pc, bus.out_inst, bus.out_err} !== 65'd0) begin
      bad++;
      $display("FAIL out_idle_zero cyc=%0d got pc=%h inst=%h err=%0b exp all zero",
               cyc, bus.out_pc, bus.out_inst, bus.out_err);
    end

    if (bus.out_valid && bus.out_ready && !redir) begin
      dut_pops++;
      if (want_first) begin
        first_pop_pc = bus.out_pc;
        want_first   = 1'b0;
      end
      if (bus.out_err) begin
        err_seen = 1'b1;
        err_pc   = bus.out_pc;
      end
    end
    if (bus.req_valid && bus.req_ready) begin
      dut_fires++;
      respq.push_back('{addr: bus.req_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
    end

    if (exp_ov && bus.out_ready && !redir) void'(expq.pop_front());
    if (bus.rsp_valid && outst.size() > 0) begin
      o = outst.pop_front();
      if (o.live && !redir) begin
        e.pc = o.addr;
        e.inst = mem_inst(o.addr);
        e.err = mem_err(o.addr);
        expq.push_back(e);
        if (e.err) halted = 1'b1;
      end
    end
    fire_m = exp_rv && bus.req_ready;
    if (fire_m) begin
      o.addr = exp_addr;
      o.live = !stale_m && !redir;
      outst.push_back(o);
      if (!stale_m) exp_next = exp_next + 32'd4;
      stale_m = 1'b0;
      pend_m  = 1'b0;
    end else begin
      pend_m    = exp_rv;
      pend_addr = exp_addr;
    end
    if (redir) begin
      foreach (outst[i]) outst[i].live = 1'b0;
      expq.delete();
      halted   = 1'b0;
      exp_next = rpc & ~32'h3;
      if (pend_m) stale_m = 1'b1;
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.req_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_req_valid got=%0b exp=0", bus.req_valid);
    end
    total++;
    if ({bus.out_valid, bus.out_pc, bus.out_inst, bus.out_err} !== 66'd0) begin
      bad++;
      $display("FAIL reset_outputs got v=%0b pc=%h inst=%h err=%0b exp all zero",
               bus.out_valid, bus.out_pc, bus.out_inst, bus.out_err);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_stream();
    int p0;
    ready_pct = 100; oready_pct = 100; lat_min = 1; lat_max = 1;
    want_first = 1'b1;
    repeat (2) step();
    p0 = dut_pops;
    repeat (20) step();
    total++;
    if (dut_pops - p0 != 20) begin
      bad++;
      $display("FAIL stream_throughput got=%0d exp=20", dut_pops - p0);
    end
    total++;
    if (first_pop_pc !== RESET_PC) begin
      bad++;
      $display("FAIL stream_first_pc got=%h exp=%h", first_pop_pc, RESET_PC);
    end
  endtask

  task automatic test_backpressure();
    ready_pct = 100; oready_pct = 0; lat_min = 1; lat_max = 1;
    step(1'b1, 32'h8000_0400);
    want_first = 1'b1;
    repeat (10) step();
    total++;
    if ({bus.out_valid, bus.req_valid} !== 2'b10) begin
      bad++;
      $display("FAIL backpressure_full got out_valid=%0b req_valid=%0b exp out_valid=1 req_valid=0",
               bus.out_valid, bus.req_valid);
    end
    oready_pct = 100;
    repeat (12) step();
    total++;
    if (first_pop_pc !== 32'h8000_0400) begin
      bad++;
      $display("FAIL backpressure_first_pc got=%h exp=80000400", first_pop_pc);
    end
  endtask

  task automatic test_redirect_outstanding();
    ready_pct = 100; oready_pct = 100; lat_min = 2; lat_max = 2;
    for (int i = 0; i < 20 && outst.size() != 2; i++) step();
    total++;
    if (outst.size() != 2) begin
      bad++;
      $display("FAIL redirect_setup_timeout got=%0d exp=2 outstanding", outst.size());
    end
    step(1'b1, 32'h8000_0100);
    want_first = 1'b1;
    repeat (12) step();
    total++;
    if (first_pop_pc !== 32'h8000_0100) begin
      bad++;
      $display("FAIL redirect_first_pc got=%h exp=80000100", first_pop_pc);
    end
  endtask

  task automatic test_redirect_pending();
    ready_pct = 0; oready_pct = 100; lat_min = 1; lat_max = 1;
    repeat (3) step();
    total++;
    if (bus.req_valid !== 1'b1) begin
      bad++;
      $display("FAIL pending_held got=%0b exp=1", bus.req_valid);
    end
    step(1'b1, 32'h8000_0102);
    step();
    ready_pct = 100;
    want_first = 1'b1;
    repeat (12) step();
    total++;
    if (first_pop_pc !== 32'h8000_0100) begin
      bad++;
      $display("FAIL pending_first_pc got=%h exp=80000100", first_pop_pc);
    end
  endtask

  task automatic test_error_halt();
    int f0;
    ready_pct = 100; oready_pct = 100; lat_min = 1; lat_max = 1;
    err_addr = 32'h8000_000C;
    err_seen = 1'b0;
    step(1'b1, RESET_PC);
    repeat (20) step();
    total++;
    if (!(err_seen && err_pc === 32'h8000_000C)) begin
      bad++;
      $display("FAIL error_delivered got seen=%0b pc=%h exp seen=1 pc=8000000c", err_seen, err_pc);
    end
    total++;
    if (bus.req_valid !== 1'b0) begin
      bad++;
      $display("FAIL error_halted got=%0b exp=0", bus.req_valid);
    end
    err_addr = '0;
    f0 = dut_fires;
    step(1'b1, 32'h8000_0200);
    want_first = 1'b1;
    repeat (10) step();
    total++;
    if (!(dut_fires > f0 && first_pop_pc === 32'h8000_0200)) begin
      bad++;
      $display("FAIL error_resume got fires=%0d first_pc=%h exp fires>0 first_pc=80000200",
               dut_fires - f0, first_pop_pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    ready_pct = 70; oready_pct = 60; lat_min = 1; lat_max = 4;
    rand_err = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 3) begin
        rpc = 32'h8000_0000 + ($urandom_range(255) << 2) + $urandom_range(3);
        step(1'b1, rpc);
      end else begin
        step();
      end
    end
    rand_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    ready_pct = 100; oready_pct = 100; lat_min = 1; lat_max = 2;
    step(1'b1, 32'h8000_0800);
    repeat (7) step();
    #2 rst = 1'b0;
    #1;
    total++;
    if ({bus.req_valid, bus.out_valid, bus.out_pc, bus.out_inst, bus.out_err} !== 67'd0) begin
      bad++;
      $display("FAIL async_reset got rv=%0b ov=%0b pc=%h inst=%h err=%0b exp all zero",
               bus.req_valid, bus.out_valid, bus.out_pc, bus.out_inst, bus.out_err);
    end
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    want_first = 1'b1;
    repeat (10) step();
    total++;
    if (first_pop_pc !== RESET_PC) begin
      bad++;
      $display("FAIL reset_restart_pc got=%h exp=%h", first_pop_pc, RESET_PC);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_pending();
    test_error_halt();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
